id_stage_p: RTL and testbench



---
 rtl/id_stage_p_pkg.sv | 58 +++++
 rtl/id_stage_p_fwd_mux.sv | 49 ++++
 rtl/id_stage_p.sv | 221 ++++++++++++++++++++++
 tb/tb_id_stage_p.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_stage_p_pkg.sv
`default_nettype none
// ============================================================================
// Module      : id_stage_p_pkg
// Description : Shared constants for the decode stage: stall-bus bit indices,
//               forwarding slot layout, MIPS opcode/function codes and the
//               branch-kind enumeration.
// Revision    : 1.0 - initial release
// ============================================================================
package id_stage_p_pkg;

  // Stall bus layout: one bit per pipeline boundary, PC first.
  localparam int STALL_W    = 6;
  localparam int STALL_IFID = 1;
  localparam int STALL_IDEX = 2;
  localparam int STALL_EX   = 3;

  localparam int REG_AW = 5;
  localparam int INST_W = 32;

  // One forwarding slot is {we, waddr, wdata}, with we in the MSB.
  function automatic int fwd_slot_w(input int data_w);
    return 1 + REG_AW + data_w;
  endfunction

  // Primary opcodes
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;

  // SPECIAL function codes
  localparam logic [5:0] FUNC_JR    = 6'h08;
  localparam logic [5:0] FUNC_JALR  = 6'h09;

  // REGIMM rt selectors
  localparam logic [4:0] RT_BLTZ    = 5'h00;
  localparam logic [4:0] RT_BGEZ    = 5'h01;

  typedef enum logic [3:0] {
    BR_NONE,
    BR_BEQ,
    BR_BNE,
    BR_BGTZ,
    BR_BLEZ,
    BR_BGEZ,
    BR_BLTZ,
    BR_J,
    BR_JAL,
    BR_JR,
    BR_JALR
  } br_kind_e;

endpackage
`default_nettype wire

// File: rtl/id_stage_p_fwd_mux.sv
`default_nettype none
// ============================================================================
// Module      : id_fwd_mux
// Description : Operand bypass for one register source. Register 0 always
//               reads zero; otherwise the lowest-numbered matching forwarding
//               slot wins, falling back to the register file.
// Revision    : 1.0 - initial release
// ============================================================================
module id_fwd_mux
  import id_stage_p_pkg::*;
#(
  parameter int NUM_FWD = 3,
  parameter int DATA_W  = 32
) (
  input  logic [REG_AW-1:0]                   raddr,
  input  logic [DATA_W-1:0]                   rf_rdata,
  input  logic [NUM_FWD*(1+REG_AW+DATA_W)-1:0] fwd_bus,
  output logic [DATA_W-1:0]                   val
);

  localparam int SLOT_W = fwd_slot_w(DATA_W);

  logic [NUM_FWD-1:0] slot_we;
  logic [REG_AW-1:0]  slot_addr [NUM_FWD];
  logic [DATA_W-1:0]  slot_data [NUM_FWD];

  generate
    for (genvar i = 0; i < NUM_FWD; i++) begin : g_slot
      assign slot_we[i]   = fwd_bus[i*SLOT_W + SLOT_W - 1];
      assign slot_addr[i] = fwd_bus[i*SLOT_W + DATA_W +: REG_AW];
      assign slot_data[i] = fwd_bus[i*SLOT_W +: DATA_W];
    end
  endgenerate

  // Scan from the oldest slot down so the youngest (slot 0) match wins.
  always_comb begin
    val = rf_rdata;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (slot_we[i] && (slot_addr[i] == raddr)) begin
        val = slot_data[i];
      end
    end
    if (raddr == '0) begin
      val = '0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/id_stage_p.sv
`default_nettype none
// ============================================================================
// Module      : id_stage_p
// Description : Instruction decode stage: IF/ID pipeline register, stall-time
//               instruction hold buffer, operand forwarding, load-use
//               interlock and early branch/jump resolution.
// Revision    : 1.0 - initial release
// ============================================================================
module id_stage_p
  import id_stage_p_pkg::*;
#(
  parameter int NUM_FWD  = 3,
  parameter int LOAD_LAT = 1,
  parameter int DATA_W   = 32
) (
  input  logic                                clk,
  input  logic                                resetn,
  input  logic [STALL_W-1:0]                  stall,
  input  logic                                flush,
  input  logic [DATA_W-1:0]                   if_pc,
  input  logic                                if_ce,
  input  logic [INST_W-1:0]                   inst_rdata,
  output logic [REG_AW-1:0]                   rf_raddr1,
  output logic [REG_AW-1:0]                   rf_raddr2,
  input  logic [DATA_W-1:0]                   rf_rdata1,
  input  logic [DATA_W-1:0]                   rf_rdata2,
  input  logic [NUM_FWD*(1+REG_AW+DATA_W)-1:0] fwd_bus,
  input  logic                                ex_is_load,
  output logic                                id_valid,
  output logic [DATA_W-1:0]                   id_pc,
  output logic [INST_W-1:0]                   id_inst,
  output logic [DATA_W-1:0]                   id_rs_val,
  output logic [DATA_W-1:0]                   id_rt_val,
  output logic                                br_taken,
  output logic [DATA_W-1:0]                   br_target,
  output logic                                stallreq
);

  localparam logic [0:0] ST_LIVE = 1'b0;
  localparam logic [0:0] ST_HELD = 1'b1;
  localparam int         CNT_W   = 3;

  logic              ifid_valid;
  logic [DATA_W-1:0] ifid_pc;
  logic [0:0]        hold_state;
  logic [INST_W-1:0] hold_buf;
  logic [CNT_W-1:0]  ld_cnt;

  logic [INST_W-1:0] inst_cur;
  logic [REG_AW-1:0] rs_addr;
  logic [REG_AW-1:0] rt_addr;
  logic [DATA_W-1:0] rs_fwd;
  logic [DATA_W-1:0] rt_fwd;
  logic [REG_AW-1:0] slot0_waddr;
  logic              hazard;
  logic              interlock;
  logic [DATA_W-1:0] pc_plus4;
  logic [DATA_W-1:0] off_target;
  logic [DATA_W-1:0] jmp_target;
  br_kind_e          br_kind;
  logic              br_cond;
  logic [DATA_W-1:0] br_dest;
  logic              rs_neg;
  logic              rs_zero;
  logic              unused_stall;

  // Stall bits for PC, MEM and WB are owned by other stages.
  assign unused_stall = ^{stall[0], stall[STALL_W-1:STALL_EX+1]};

  // IF/ID register: flush beats everything, a stalled ID with a moving EX
  // injects a bubble, otherwise capture or hold.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ifid_valid <= 1'b0;
      ifid_pc    <= '0;
    end else if (flush) begin
      ifid_valid <= 1'b0;
    end else if (stall[STALL_IFID] && !stall[STALL_IDEX]) begin
      ifid_valid <= 1'b0;
      ifid_pc    <= '0;
    end else if (!stall[STALL_IFID]) begin
      ifid_valid <= if_ce;
      ifid_pc    <= if_pc;
    end
  end

  // The SRAM output moves on while ID is stalled, so snapshot it on the
  // first stalled cycle and serve it from hold_buf until the stall lifts.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hold_state <= ST_LIVE;
      hold_buf   <= '0;
    end else if (flush) begin
      hold_state <= ST_LIVE;
    end else begin
      case (hold_state)
        ST_LIVE: begin
          if (stall[STALL_IFID]) begin
            hold_buf   <= inst_rdata;
            hold_state <= ST_HELD;
          end
        end
        ST_HELD: begin
          if (!stall[STALL_IFID]) begin
            hold_state <= ST_LIVE;
          end
        end
        default: hold_state <= ST_LIVE;
      endcase
    end
  end

  assign inst_cur = (hold_state == ST_HELD) ? hold_buf : inst_rdata;
  assign rs_addr  = inst_cur[25:21];
  assign rt_addr  = inst_cur[20:16];

  id_fwd_mux #(
    .NUM_FWD (NUM_FWD),
    .DATA_W  (DATA_W)
  ) u_fwd_rs (
    .raddr    (rs_addr),
    .rf_rdata (rf_rdata1),
    .fwd_bus  (fwd_bus),
    .val      (rs_fwd)
  );

  id_fwd_mux #(
    .NUM_FWD (NUM_FWD),
    .DATA_W  (DATA_W)
  ) u_fwd_rt (
    .raddr    (rt_addr),
    .rf_rdata (rf_rdata2),
    .fwd_bus  (fwd_bus),
    .val      (rt_fwd)
  );

  // Slot 0 is the EX stage; its destination is known before the load data.
  assign slot0_waddr = fwd_bus[DATA_W +: REG_AW];
  assign hazard      = ifid_valid && ex_is_load && (slot0_waddr != '0) &&
                       ((slot0_waddr == rs_addr) || (slot0_waddr == rt_addr));

  // Extend the interlock for loads whose data arrives later than MEM.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ld_cnt <= '0;
    end else if (hazard) begin
      ld_cnt <= CNT_W'(LOAD_LAT - 1);
    end else if ((ld_cnt != '0) && !stall[STALL_EX]) begin
      ld_cnt <= ld_cnt - 1'b1;
    end
  end

  assign interlock = hazard || (ld_cnt != '0);

  assign pc_plus4   = ifid_pc + DATA_W'(4);
  assign off_target = pc_plus4 + {{(DATA_W-18){inst_cur[15]}}, inst_cur[15:0], 2'b00};
  assign jmp_target = {pc_plus4[DATA_W-1:28], inst_cur[25:0], 2'b00};
  assign rs_neg     = rs_fwd[DATA_W-1];
  assign rs_zero    = (rs_fwd == '0);

  // Classify the control-transfer instruction, if any.
  always_comb begin
    br_kind = BR_NONE;
    case (inst_cur[31:26])
      OP_SPECIAL: begin
        if (inst_cur[5:0] == FUNC_JR) begin
          br_kind = BR_JR;
        end else if (inst_cur[5:0] == FUNC_JALR) begin
          br_kind = BR_JALR;
        end
      end
      OP_REGIMM: begin
        if (rt_addr == RT_BLTZ) begin
          br_kind = BR_BLTZ;
        end else if (rt_addr == RT_BGEZ) begin
          br_kind = BR_BGEZ;
        end
      end
      OP_J:    br_kind = BR_J;
      OP_JAL:  br_kind = BR_JAL;
      OP_BEQ:  br_kind = BR_BEQ;
      OP_BNE:  br_kind = BR_BNE;
      OP_BLEZ: br_kind = BR_BLEZ;
      OP_BGTZ: br_kind = BR_BGTZ;
      default: br_kind = BR_NONE;
    endcase
  end

  // Evaluate the branch condition on forwarded operands and pick a target.
  always_comb begin
    br_cond = 1'b0;
    br_dest = '0;
    case (br_kind)
      BR_BEQ:  begin br_cond = (rs_fwd == rt_fwd);   br_dest = off_target; end
      BR_BNE:  begin br_cond = (rs_fwd != rt_fwd);   br_dest = off_target; end
      BR_BGTZ: begin br_cond = !rs_neg && !rs_zero;  br_dest = off_target; end
      BR_BLEZ: begin br_cond = rs_neg || rs_zero;    br_dest = off_target; end
      BR_BGEZ: begin br_cond = !rs_neg;              br_dest = off_target; end
      BR_BLTZ: begin br_cond = rs_neg;               br_dest = off_target; end
      BR_J,
      BR_JAL:  begin br_cond = 1'b1;                 br_dest = jmp_target; end
      BR_JR,
      BR_JALR: begin br_cond = 1'b1;                 br_dest = rs_fwd;     end
      default: begin br_cond = 1'b0;                 br_dest = '0;         end
    endcase
  end

  // Everything except the PC reads as zero while the IF/ID slot is empty.
  assign id_valid  = ifid_valid;
  assign id_pc     = ifid_pc;
  assign id_inst   = ifid_valid ? inst_cur : '0;
  assign rf_raddr1 = ifid_valid ? rs_addr : '0;
  assign rf_raddr2 = ifid_valid ? rt_addr : '0;
  assign id_rs_val = ifid_valid ? rs_fwd : '0;
  assign id_rt_val = ifid_valid ? rt_fwd : '0;
  assign stallreq  = ifid_valid && interlock;
  assign br_taken  = ifid_valid && !interlock && br_cond;
  assign br_target = ifid_valid ? br_dest : '0;

endmodule
`default_nettype wire

// File: tb/tb_id_stage_p.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_stage_p
// Description : Directed self-checking bench for id_stage_p with a queue of
//               expected output values compared once outputs settle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_stage_p;

  localparam int NUM_FWD  = 3;
  localparam int LOAD_LAT = 2;
  localparam int DATA_W   = 32;
  localparam int SLOT_W   = 1 + 5 + DATA_W;

  logic                        clk;
  logic                        resetn;
  logic [5:0]                  stall;
  logic                        flush;
  logic [DATA_W-1:0]           if_pc;
  logic                        if_ce;
  logic [31:0]                 inst_rdata;
  logic [4:0]                  rf_raddr1;
  logic [4:0]                  rf_raddr2;
  logic [DATA_W-1:0]           rf_rdata1;
  logic [DATA_W-1:0]           rf_rdata2;
  logic [NUM_FWD*SLOT_W-1:0]   fwd_bus;
  logic                        ex_is_load;
  logic                        id_valid;
  logic [DATA_W-1:0]           id_pc;
  logic [31:0]                 id_inst;
  logic [DATA_W-1:0]           id_rs_val;
  logic [DATA_W-1:0]           id_rt_val;
  logic                        br_taken;
  logic [DATA_W-1:0]           br_target;
  logic                        stallreq;

  id_stage_p #(
    .NUM_FWD  (NUM_FWD),
    .LOAD_LAT (LOAD_LAT),
    .DATA_W   (DATA_W)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .stall      (stall),
    .flush      (flush),
    .if_pc      (if_pc),
    .if_ce      (if_ce),
    .inst_rdata (inst_rdata),
    .rf_raddr1  (rf_raddr1),
    .rf_raddr2  (rf_raddr2),
    .rf_rdata1  (rf_rdata1),
    .rf_rdata2  (rf_rdata2),
    .fwd_bus    (fwd_bus),
    .ex_is_load (ex_is_load),
    .id_valid   (id_valid),
    .id_pc      (id_pc),
    .id_inst    (id_inst),
    .id_rs_val  (id_rs_val),
    .id_rt_val  (id_rt_val),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .stallreq   (stallreq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {
    S_VALID, S_PC, S_INST, S_RS, S_RT, S_BRT, S_BRTGT, S_STALLREQ, S_RA1, S_RA2
  } sel_e;

  typedef struct {
    string       tag;
    sel_e        sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  function automatic logic [31:0] observe(input sel_e s);
    case (s)
      S_VALID:    return {31'b0, id_valid};
      S_PC:       return id_pc;
      S_INST:     return id_inst;
      S_RS:       return id_rs_val;
      S_RT:       return id_rt_val;
      S_BRT:      return {31'b0, br_taken};
      S_BRTGT:    return br_target;
      S_STALLREQ: return {31'b0, stallreq};
      S_RA1:      return {27'b0, rf_raddr1};
      S_RA2:      return {27'b0, rf_raddr2};
      default:    return 32'hDEADBEEF;
    endcase
  endfunction

  task automatic expect_val(input string tag, input sel_e s, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = s;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t        e;
    logic [31:0] obs;
    #2;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sel);
      vectors++;
      assert (obs === e.exp) else begin
        miscompares++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input int s, input logic we, input logic [4:0] a,
                          input logic [31:0] d);
    fwd_bus[s*SLOT_W +: SLOT_W] = {we, a, d};
  endtask

  task automatic quiet();
    fwd_bus    = '0;
    ex_is_load = 1'b0;
    stall      = 6'b0;
    flush      = 1'b0;
    rf_rdata1  = '0;
    rf_rdata2  = '0;
  endtask

  // Capture pc at the next edge, then present the SRAM word one cycle later.
  task automatic issue(input logic [31:0] pc, input logic [31:0] inst);
    quiet();
    if_pc = pc;
    if_ce = 1'b1;
    tick();
    inst_rdata = inst;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn     = 1'b1;
    if_pc      = '0;
    if_ce      = 1'b0;
    inst_rdata = '0;
    quiet();
    #1 resetn = 1'b0;

    // Reset state
    expect_val("rst_valid", S_VALID, 32'h0);
    expect_val("rst_pc", S_PC, 32'h0);
    expect_val("rst_inst", S_INST, 32'h0);
    expect_val("rst_stallreq", S_STALLREQ, 32'h0);
    expect_val("rst_brt", S_BRT, 32'h0);
    check();
    tick();
    tick();
    resetn = 1'b1;

    // Forwarding priority: EX slot beats WB slot
    issue(32'h100, 32'h00221821);
    set_slot(0, 1'b1, 5'd1, 32'h5);
    set_slot(2, 1'b1, 5'd1, 32'h9);
    rf_rdata1 = 32'hAAAA;
    rf_rdata2 = 32'hBBBB;
    expect_val("fwd_valid", S_VALID, 32'h1);
    expect_val("fwd_pc", S_PC, 32'h100);
    expect_val("fwd_inst", S_INST, 32'h00221821);
    expect_val("fwd_rs_ex", S_RS, 32'h5);
    expect_val("fwd_rt_rf", S_RT, 32'hBBBB);
    expect_val("fwd_ra1", S_RA1, 32'h1);
    expect_val("fwd_ra2", S_RA2, 32'h2);
    expect_val("fwd_stallreq", S_STALLREQ, 32'h0);
    expect_val("fwd_brt", S_BRT, 32'h0);
    check();

    // Disabled slot ignored; MEM beats WB
    issue(32'h104, 32'h00221821);
    set_slot(0, 1'b0, 5'd1, 32'h5);
    set_slot(1, 1'b1, 5'd2, 32'h77);
    set_slot(2, 1'b1, 5'd2, 32'h88);
    rf_rdata1 = 32'hAAAA;
    expect_val("fwd2_rs_rf", S_RS, 32'hAAAA);
    expect_val("fwd2_rt_mem", S_RT, 32'h77);
    check();

    // Register 0 is never forwarded
    issue(32'h108, 32'h00021821);
    set_slot(0, 1'b1, 5'd0, 32'hFF);
    rf_rdata1 = 32'h1234;
    expect_val("r0_rs", S_RS, 32'h0);
    expect_val("r0_ra1", S_RA1, 32'h0);
    check();

    // beq backwards to itself
    issue(32'h1000, 32'h1021FFFF);
    rf_rdata1 = 32'h42;
    rf_rdata2 = 32'h42;
    expect_val("beq_taken", S_BRT, 32'h1);
    expect_val("beq_target", S_BRTGT, 32'h1000);
    check();

    issue(32'h1000, 32'h1421FFFF);
    rf_rdata1 = 32'h42;
    rf_rdata2 = 32'h42;
    expect_val("bne_not_taken", S_BRT, 32'h0);
    check();

    issue(32'hF0000000, 32'h08000040);
    expect_val("j_taken", S_BRT, 32'h1);
    expect_val("j_target", S_BRTGT, 32'hF0000100);
    check();

    issue(32'h2000, 32'h00A00008);
    rf_rdata1 = 32'h3000;
    set_slot(1, 1'b1, 5'd5, 32'h4444);
    expect_val("jr_taken", S_BRT, 32'h1);
    expect_val("jr_target_fwd", S_BRTGT, 32'h4444);
    check();

    issue(32'h200, 32'h04200010);
    rf_rdata1 = 32'h80000000;
    expect_val("bltz_taken", S_BRT, 32'h1);
    expect_val("bltz_target", S_BRTGT, 32'h244);
    check();

    issue(32'h200, 32'h1C200010);
    rf_rdata1 = 32'h80000000;
    expect_val("bgtz_neg", S_BRT, 32'h0);
    check();

    // Branch held back by a load-use interlock
    issue(32'h1000, 32'h1021FFFF);
    rf_rdata1  = 32'h42;
    rf_rdata2  = 32'h42;
    ex_is_load = 1'b1;
    set_slot(0, 1'b1, 5'd1, 32'h42);
    expect_val("brlu_stallreq", S_STALLREQ, 32'h1);
    expect_val("brlu_brt", S_BRT, 32'h0);
    check();

    // Flush wins over a simultaneous stall
    issue(32'h700, 32'h00221821);
    expect_val("flush_pre_valid", S_VALID, 32'h1);
    check();
    flush = 1'b1;
    stall = 6'b000110;
    tick();
    flush = 1'b0;
    expect_val("flush_valid", S_VALID, 32'h0);
    expect_val("flush_inst", S_INST, 32'h0);
    expect_val("flush_stallreq", S_STALLREQ, 32'h0);
    check();

    // Load-use with LOAD_LAT=2: two interlock cycles, then MEM data
    issue(32'h300, 32'h00842821);
    ex_is_load = 1'b1;
    set_slot(0, 1'b1, 5'd4, 32'hDEAD);
    stall     = 6'b000110;
    rf_rdata1 = 32'h11;
    rf_rdata2 = 32'h22;
    expect_val("lu_c1_stallreq", S_STALLREQ, 32'h1);
    expect_val("lu_c1_inst", S_INST, 32'h00842821);
    check();
    tick();
    ex_is_load = 1'b0;
    set_slot(0, 1'b0, 5'd0, 32'h0);
    inst_rdata = 32'hFFFFFFFF;
    expect_val("lu_c2_stallreq", S_STALLREQ, 32'h1);
    expect_val("lu_c2_inst", S_INST, 32'h00842821);
    expect_val("lu_c2_pc", S_PC, 32'h300);
    check();
    tick();
    stall = 6'b0;
    set_slot(1, 1'b1, 5'd4, 32'hCAFE);
    expect_val("lu_c3_stallreq", S_STALLREQ, 32'h0);
    expect_val("lu_c3_rs", S_RS, 32'hCAFE);
    expect_val("lu_c3_rt", S_RT, 32'hCAFE);
    expect_val("lu_c3_valid", S_VALID, 32'h1);
    check();

    // Instruction held across a 3-cycle stall while SRAM output moves
    issue(32'h400, 32'h24020007);
    stall = 6'b000110;
    expect_val("hold_c1_inst", S_INST, 32'h24020007);
    check();
    tick();
    inst_rdata = 32'h11111111;
    expect_val("hold_c2_inst", S_INST, 32'h24020007);
    expect_val("hold_c2_valid", S_VALID, 32'h1);
    check();
    tick();
    inst_rdata = 32'h22222222;
    expect_val("hold_c3_inst", S_INST, 32'h24020007);
    check();
    tick();
    stall      = 6'b0;
    inst_rdata = 32'h33333333;
    expect_val("hold_c4_inst", S_INST, 32'h24020007);
    expect_val("hold_c4_ra2", S_RA2, 32'h2);
    check();

    // Stalled ID with a moving EX inserts a bubble
    quiet();
    stall = 6'b000010;
    tick();
    expect_val("bubble_valid", S_VALID, 32'h0);
    expect_val("bubble_pc", S_PC, 32'h0);
    expect_val("bubble_inst", S_INST, 32'h0);
    check();

    // Asynchronous reset while HELD, then cold-start capture
    issue(32'h500, 32'h00221821);
    stall = 6'b000110;
    tick();
    inst_rdata = 32'h99999999;
    expect_val("rh_held_inst", S_INST, 32'h00221821);
    check();
    resetn = 1'b0;
    expect_val("rh_valid", S_VALID, 32'h0);
    expect_val("rh_pc", S_PC, 32'h0);
    expect_val("rh_inst", S_INST, 32'h0);
    expect_val("rh_ra1", S_RA1, 32'h0);
    check();
    tick();
    resetn = 1'b1;
    quiet();
    issue(32'h600, 32'h00842821);
    expect_val("rh_post_valid", S_VALID, 32'h1);
    expect_val("rh_post_inst_live", S_INST, 32'h00842821);
    expect_val("rh_post_pc", S_PC, 32'h600);
    check();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
